ram_banked: RTL and testbench

RAM_BANKED -- requirements
Module: ram_banked

---
 rtl/ram_banked.sv | 145 ++++++++++++++
 tb/tb_ram_banked.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_banked.sv
// ============================================================================
//  Module   : ram_banked
//  Purpose  : Single-port word RAM with byte-enable writes, ready/valid request
//             and response channels, and a post-reset / soft-clear init sweep.
//             Optional macro RAM_INIT_INDEX_EN: sweep writes mem[idx]=idx
//             instead of zero.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_banked #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              clr_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [WIDTH-1:0]  req_wd_i,
   input  logic [WIDTH/8-1:0] req_be_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [WIDTH-1:0]  rsp_rd_o,
   output logic              init_done_o
);

   localparam int              NB      = WIDTH / 8;
   localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(DEPTH - 1);

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   logic [WIDTH-1:0]  mem [DEPTH];

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              init_done_q, init_done_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0]  rsp_rd_q, rsp_rd_d;

   logic              w_in_range;
   logic              w_ready;
   logic              w_rd_acc;
   logic              w_wr_acc;
   logic [WIDTH-1:0]  w_init_word;

   // Zero-extended compare so DEPTH equal to 2**ADDR_W still works.
   assign w_in_range = ({1'b0, req_addr_i} < C_DEPTH);

   // Requests are refused while sweeping, on the clear cycle, and whenever the
   // response register is full and not being drained this cycle.
   assign w_ready  = (state_q == ST_RUN) && !clr_i && (!rsp_valid_q || rsp_ready_i);
   assign w_rd_acc = req_valid_i && w_ready && !req_we_i;
   assign w_wr_acc = req_valid_i && w_ready &&  req_we_i && w_in_range;

`ifdef RAM_INIT_INDEX_EN
   assign w_init_word = WIDTH'(idx_q);
`else
   assign w_init_word = '0;
`endif

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      init_done_d = init_done_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rd_d    = rsp_rd_q;

      case (state_q)
         ST_INIT: begin
            if (idx_q == C_LAST) begin
               state_d     = ST_RUN;
               idx_d       = '0;
               init_done_d = 1'b1;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_RUN: begin
            if (clr_i) begin
               state_d     = ST_INIT;
               idx_d       = '0;
               init_done_d = 1'b0;
            end
         end
         default: begin
            state_d     = ST_INIT;
            idx_d       = '0;
            init_done_d = 1'b0;
         end
      endcase

      // A pending response drains independently of the FSM state.
      if (w_rd_acc) begin
         rsp_valid_d = 1'b1;
         rsp_rd_d    = w_in_range ? mem[req_addr_i] : '0;
      end else if (rsp_ready_i) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= ST_INIT;
         idx_q       <= '0;
         init_done_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rd_q    <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         init_done_q <= init_done_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rd_q    <= rsp_rd_d;
      end
   end

   // Storage has no reset; its contents are defined by the sweep.
   always_ff @(posedge clk_i) begin
      if (rst_n_i && (state_q == ST_INIT)) begin
         mem[idx_q] <= w_init_word;
      end else if (w_wr_acc) begin
         for (int b = 0; b < NB; b++) begin
            if (req_be_i[b]) begin
               mem[req_addr_i][8*b +: 8] <= req_wd_i[8*b +: 8];
            end
         end
      end
   end

   assign req_ready_o = w_ready;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rd_o    = rsp_rd_q;
   assign init_done_o = init_done_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_banked.sv
// ============================================================================
//  Module   : tb_ram_banked
//  Purpose  : Self-checking bench for ram_banked (DEPTH 1024 plus a DEPTH 1000
//             instance for out-of-range addressing). Honours RAM_INIT_INDEX_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ram_banked;

   localparam int W  = 32;
   localparam int D  = 1024;
   localparam int DB = 1000;
   localparam int AW = 10;

`ifdef RAM_INIT_INDEX_EN
   localparam logic [31:0] C_P3   = 32'd3;
   localparam logic [31:0] C_P5   = 32'd5;
   localparam logic [31:0] C_P10  = 32'h0000_000A;
   localparam logic [31:0] C_P999 = 32'd999;
`else
   localparam logic [31:0] C_P3   = 32'd0;
   localparam logic [31:0] C_P5   = 32'd0;
   localparam logic [31:0] C_P10  = 32'd0;
   localparam logic [31:0] C_P999 = 32'd0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          clr, req_valid, req_we, rsp_ready;
   logic [AW-1:0] req_addr;
   logic [W-1:0]  req_wd;
   logic [3:0]    req_be;
   logic          req_ready, rsp_valid, init_done;
   logic [W-1:0]  rsp_rd;

   logic          b_clr, b_valid, b_we, b_rsp_ready;
   logic [AW-1:0] b_addr;
   logic [W-1:0]  b_wd;
   logic [3:0]    b_be;
   logic          b_req_ready, b_rsp_valid, b_init_done;
   logic [W-1:0]  b_rsp_rd;

   int n_cmp = 0;
   int n_err = 0;

   ram_banked #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW)) u_dut (
      .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
      .req_addr_i(req_addr), .req_wd_i(req_wd), .req_be_i(req_be),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rd_o(rsp_rd),
      .init_done_o(init_done)
   );

   ram_banked #(.WIDTH(W), .DEPTH(DB), .ADDR_W(AW)) u_dut_odd (
      .clk_i(clk), .rst_n_i(rst_n), .clr_i(b_clr),
      .req_valid_i(b_valid), .req_ready_o(b_req_ready), .req_we_i(b_we),
      .req_addr_i(b_addr), .req_wd_i(b_wd), .req_be_i(b_be),
      .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_rd_o(b_rsp_rd),
      .init_done_o(b_init_done)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] pat(input int i);
`ifdef RAM_INIT_INDEX_EN
      return 32'(i);
`else
      return 32'd0;
`endif
   endfunction

   // Transaction model: memory image, remaining sweep cycles, response slot.
   logic [31:0] mdl [D];
   int          init_cnt  = D;
   logic        exp_valid = 1'b0;
   logic [31:0] exp_rd    = '0;

   initial forever begin
      logic rdy;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         init_cnt  = D;
         exp_valid = 1'b0;
         exp_rd    = '0;
      end else if (init_cnt > 0) begin
         mdl[D - init_cnt] = pat(D - init_cnt);
         init_cnt--;
         if (rsp_ready) exp_valid = 1'b0;
      end else begin
         rdy = !clr && (!exp_valid || rsp_ready);
         if (clr) init_cnt = D;
         if (req_valid && rdy && req_we) begin
            for (int b = 0; b < 4; b++)
               if (req_be[b] && int'(req_addr) < D) mdl[req_addr][8*b +: 8] = req_wd[8*b +: 8];
         end
         if (req_valid && rdy && !req_we) begin
            exp_valid = 1'b1;
            exp_rd    = (int'(req_addr) < D) ? mdl[req_addr] : 32'd0;
         end else if (rsp_ready) begin
            exp_valid = 1'b0;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      chk("cyc_req_ready", {31'd0, req_ready},
          {31'd0, rst_n && init_cnt == 0 && !clr && (!exp_valid || rsp_ready)});
      chk("cyc_init_done", {31'd0, init_done}, {31'd0, rst_n && init_cnt == 0});
      chk("cyc_rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_valid});
      chk("cyc_rsp_rd", rsp_rd, exp_rd);
   end

   task automatic slot();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      req_valid = 1'b0;
      req_we    = 1'b0;
      clr       = 1'b0;
      rsp_ready = 1'b1;
   endtask

   task automatic issue(input logic we, input logic [AW-1:0] a, input logic [31:0] d,
                        input logic [3:0] be, output logic [31:0] rd);
      int k = 0;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wd    = d;
      req_be    = be;
      rsp_ready = 1'b1;
      while (!req_ready && k < 20) begin
         slot();
         k++;
      end
      chk("accept", {31'd0, req_ready}, 32'd1);
      slot();
      rd = rsp_rd;
      req_valid = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int exp_n);
      int n = 0;
      while (!init_done && n < 2000) begin
         slot();
         n++;
      end
      chk(nm, n, exp_n);
   endtask

   initial begin
      logic [31:0] rd;
      rst_n = 1'b1;
      idle();
      req_addr = '0; req_wd = '0; req_be = '0;
      b_clr = 1'b0; b_valid = 1'b0; b_we = 1'b0; b_rsp_ready = 1'b1;
      b_addr = '0; b_wd = '0; b_be = '0;
      #1 rst_n = 1'b0;
      repeat (3) slot();
      chk("rst_init_done", {31'd0, init_done}, 32'd0);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
      rst_n = 1'b1;
      wait_done("init_cycles", D);

      // Out-of-range handling on the DEPTH=1000 instance.
      chk("odd_init_done", {31'd0, b_init_done}, 32'd1);
      b_valid = 1'b1; b_we = 1'b1; b_addr = 10'd1000; b_wd = 32'h1234_5678; b_be = 4'hF;
      #1 chk("odd_ready", {31'd0, b_req_ready}, 32'd1);
      slot();
      b_we = 1'b0;
      slot();
      chk("odd_rd1000_v", {31'd0, b_rsp_valid}, 32'd1);
      chk("odd_rd1000", b_rsp_rd, 32'd0);
      b_addr = 10'd999;
      slot();
      chk("odd_rd999", b_rsp_rd, C_P999);
      b_valid = 1'b0;

      issue(1'b0, 10'd5, '0, '0, rd);
      chk("rd_addr5", rd, C_P5);
      issue(1'b0, 10'd10, '0, '0, rd);
      chk("rd_addr10_init", rd, C_P10);
      issue(1'b1, 10'd10, 32'hDEAD_BEEF, 4'b0101, rd);
      issue(1'b0, 10'd10, '0, '0, rd);
      chk("rd_addr10_be", rd, 32'h00AD_00EF);

      // Stalled back-to-back reads.
      for (int i = 1; i <= 3; i++) issue(1'b1, AW'(i), 32'(i), 4'hF, rd);
      slot();
      req_valid = 1'b1; req_we = 1'b0; req_addr = 10'd1;
      slot();
      req_addr = 10'd2; rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_rd", rsp_rd, 32'd1);
         chk("stall_ready", {31'd0, req_ready}, 32'd0);
         slot();
      end
      rsp_ready = 1'b1;
      slot();
      chk("b2b_rd2", rsp_rd, 32'd2);
      req_addr = 10'd3;
      slot();
      chk("b2b_rd3", rsp_rd, 32'd3);
      idle();
      slot();

      // Soft clear with a response still pending.
      issue(1'b1, 10'd0, 32'h0000_FFFF, 4'hF, rd);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 10'd2;
      slot();
      req_addr = 10'd7; clr = 1'b1; rsp_ready = 1'b0;
      #1 chk("clr_ready", {31'd0, req_ready}, 32'd0);
      slot();
      req_valid = 1'b0; clr = 1'b0;
      chk("clr_done_drop", {31'd0, init_done}, 32'd0);
      chk("clr_pending_rd", rsp_rd, 32'd2);
      rsp_ready = 1'b1;
      wait_done("clr_cycles", D);
      issue(1'b0, 10'd0, '0, '0, rd);
      chk("rd_addr0_after_clr", rd, 32'd0);

      // Asynchronous reset with a response held.
      req_valid = 1'b1; req_we = 1'b0; req_addr = 10'd3;
      slot();
      req_valid = 1'b0; rsp_ready = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("arst_rsp_rd", rsp_rd, 32'd0);
      chk("arst_init_done", {31'd0, init_done}, 32'd0);
      slot();
      rst_n = 1'b1; rsp_ready = 1'b1;
      repeat (500) slot();
      #1 rst_n = 1'b0;
      #1 chk("arst_mid_sweep_ready", {31'd0, req_ready}, 32'd0);
      slot();
      rst_n = 1'b1;
      wait_done("resweep_cycles", D);
      issue(1'b0, 10'd3, '0, '0, rd);
      chk("rd_addr3_after_reset", rd, C_P3);
      idle();
      repeat (3) slot();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
